branch_predictor: RTL and testbench

- Parametrised direction predictor for the Riscv151 fetch stage.
- Holds a table of saturating counters indexed by PC.
- Fetch issues a lookup and gets a registered taken/not-taken prediction one cycle later. Execute writes back each resolved B-type outcome.
- Also keeps branch and mispredict statistics for the B-type assembly regressions, and supports an optional gshare indexing mode.

---
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup, update, flush and statistics signals of the branch predictor.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            busy;
  logic            lk_valid;
  logic [XLEN-1:0] lk_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_mispredict;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
  modport master (
    output flush, lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_mispredict,
    input  busy, pred_valid, pred_taken, stat_branches, stat_mispredicts
  );
  modport slave (
    input  flush, lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_mispredict,
    output busy, pred_valid, pred_taken, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: saturating-counter direction predictor with init sweep and statistics.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 6
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] MAX = '1;
  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(ENTRIES - 1);
  typedef enum logic {INIT, RUN} state_e;
  state_e              state_q;
  logic [IDX_BITS-1:0] ptr_q;
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;
  logic [IDX_BITS-1:0] lk_idx, upd_idx, hist;
  logic [GHR_BITS-1:0] ghr;
  logic                pred_valid_q, pred_taken_q, accept;
  logic [31:0]         br_q, mp_q;
  logic                unused_ok;
`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;
  // Updates see the history before their own outcome is shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else if (bp.flush) ghr_q <= '0;
    else if (accept) ghr_q <= GHR_BITS'({ghr_q, bp.upd_taken});
  end
  assign ghr = ghr_q;
`else
  assign ghr = '0;
`endif
  assign hist = IDX_BITS'(ghr);
  assign unused_ok = ^{bp.lk_pc[XLEN-1:IDX_BITS+2], bp.lk_pc[1:0], bp.upd_pc[XLEN-1:IDX_BITS+2], bp.upd_pc[1:0]};
  always_comb begin
    lk_idx  = bp.lk_pc[IDX_BITS+1:2] ^ hist;
    upd_idx = bp.upd_pc[IDX_BITS+1:2] ^ hist;
    ctr_cur = ctr_q[upd_idx];
    ctr_d   = bp.upd_taken ? (ctr_cur == MAX ? ctr_cur : ctr_cur + CTR_BITS'(1))
                           : (ctr_cur == '0 ? ctr_cur : ctr_cur - CTR_BITS'(1));
    accept  = state_q == RUN && bp.upd_valid && !bp.flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      br_q         <= '0;
      mp_q         <= '0;
    end else begin
      pred_valid_q <= bp.lk_valid;
      pred_taken_q <= bp.lk_valid && state_q == RUN && ctr_q[lk_idx][CTR_BITS-1];
      if (bp.flush) begin
        state_q <= INIT;
        ptr_q   <= '0;
      end else if (state_q == INIT) begin
        ptr_q <= ptr_q + IDX_BITS'(1);
        if (ptr_q == LAST) state_q <= RUN;
      end
      if (accept) begin
        br_q <= br_q + 32'(br_q != '1);
        if (bp.upd_mispredict) mp_q <= mp_q + 32'(mp_q != '1);
      end
    end
  end
  // Table has no reset: the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (state_q == INIT) ctr_q[ptr_q] <= WNT;
    else if (accept) ctr_q[upd_idx] <= ctr_d;
  end
  assign bp.busy             = state_q == INIT;
  assign bp.pred_valid       = pred_valid_q;
  assign bp.pred_taken       = pred_taken_q;
  assign bp.stat_branches    = br_q;
  assign bp.stat_mispredicts = mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks of branch_predictor against a behavioural model.
module tb_branch_predictor;
  localparam int E = 64;
  localparam int WNT = 1;
  localparam int MAXC = 3;
  localparam int HALF = 2;
  localparam int GB = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mdl [E];
  longint m_br, m_mp;
  int busy_left;
  int ghr;
  bit exp_pv, exp_pt;
  branch_predictor_if #(.XLEN(32)) bp ();
  branch_predictor dut (.clk(clk), .rst_n(rst_n), .bp(bp));
  always #5 clk = ~clk;
  function automatic int midx(logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return int'((pc >> 2) % E) ^ ghr;
`else
    return int'((pc >> 2) % E);
`endif
  endfunction
  task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input bit um, input bit fl);
    bp.lk_valid = lv; bp.lk_pc = lpc; bp.upd_valid = uv; bp.upd_pc = upc;
    bp.upd_taken = ut; bp.upd_mispredict = um; bp.flush = fl;
  endtask
  // Advance one clock, predicting the outputs that the edge will produce.
  task automatic cyc();
    int i;
    exp_pv = bp.lk_valid;
    exp_pt = bp.lk_valid && busy_left == 0 && mdl[midx(bp.lk_pc)] >= HALF;
    if (bp.flush) begin
      busy_left = E;
      foreach (mdl[k]) mdl[k] = WNT;
      ghr = 0;
    end else if (busy_left > 0) busy_left--;
    else if (bp.upd_valid) begin
      i = midx(bp.upd_pc);
      mdl[i] = bp.upd_taken ? (mdl[i] < MAXC ? mdl[i] + 1 : MAXC) : (mdl[i] > 0 ? mdl[i] - 1 : 0);
      if (m_br < 64'hFFFFFFFF) m_br++;
      if (bp.upd_mispredict && m_mp < 64'hFFFFFFFF) m_mp++;
      ghr = ((ghr << 1) | int'(bp.upd_taken)) % (1 << GB);
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    foreach (mdl[k]) mdl[k] = WNT;
    m_br = 0; m_mp = 0; ghr = 0; busy_left = E;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    int n;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bp.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bp.busy); end
    checks++; if (bp.pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b want 0", bp.pred_valid); end
    checks++; if (bp.stat_branches !== 32'd0 || bp.stat_mispredicts !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", bp.stat_branches, bp.stat_mispredicts); end
    foreach (mdl[k]) mdl[k] = WNT;
    m_br = 0; m_mp = 0; ghr = 0; busy_left = E;
    rst_n = 1'b1;
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    cyc();
    checks++; if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b0) begin
      errors++; $display("FAIL init_lookup: got v=%b t=%b want v=1 t=0", bp.pred_valid, bp.pred_taken); end
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 1;
    while (bp.busy === 1'b1 && n < 200) begin cyc(); n++; end
    checks++; if (n != E) begin errors++; $display("FAIL busy_len: got %0d cycles want %0d", n, E); end
  endtask
`ifndef BP_GSHARE_EN
  task automatic test_training();
    repeat (2) begin drive(0, 0, 1, 32'h100, 1, 0, 0); cyc(); end
    drive(1, 32'h100, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b1) begin errors++; $display("FAIL train_100: got %b want 1", bp.pred_taken); end
    drive(1, 32'h104, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++; $display("FAIL train_104: got %b want 0", bp.pred_taken); end
    drive(1, 32'h200, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_200: got %b want 1", bp.pred_taken); end
  endtask
  task automatic test_saturation();
    repeat (5) begin drive(0, 0, 1, 32'h40, 1, 0, 0); cyc(); end
    drive(0, 0, 1, 32'h40, 0, 0, 0); cyc();
    drive(1, 32'h40, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi: got %b want 1", bp.pred_taken); end
    repeat (2) begin drive(0, 0, 1, 32'h40, 0, 0, 0); cyc(); end
    drive(1, 32'h40, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++; $display("FAIL sat_mid: got %b want 0", bp.pred_taken); end
    repeat (5) begin drive(0, 0, 1, 32'h40, 0, 0, 0); cyc(); end
    drive(0, 0, 1, 32'h40, 1, 0, 0); cyc();
    drive(1, 32'h40, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++; $display("FAIL sat_lo: got %b want 0", bp.pred_taken); end
  endtask
  task automatic test_conflict();
    drive(1, 32'h80, 1, 32'h80, 1, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_same: got %b want 0", bp.pred_taken); end
    drive(1, 32'h80, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b1) begin errors++; $display("FAIL rbw_next: got %b want 1", bp.pred_taken); end
  endtask
  task automatic test_flush();
    int n;
    do_reset();
    repeat (E) cyc();
    checks++; if (bp.busy !== 1'b0) begin errors++; $display("FAIL flush_pre_busy: got %b want 0", bp.busy); end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, i < 2 ? 32'h100 : 32'h104 + 32'(4 * i), 1, i < 3, 0); cyc();
    end
    checks++; if (bp.stat_branches !== 32'd10 || bp.stat_mispredicts !== 32'd3) begin
      errors++; $display("FAIL flush_pre_stats: got %0d/%0d want 10/3", bp.stat_branches, bp.stat_mispredicts); end
    drive(0, 0, 1, 32'h100, 1, 1, 1); cyc();
    drive(0, 0, 1, 32'h100, 1, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 1;
    while (bp.busy === 1'b1 && n < 200) begin cyc(); n++; end
    checks++; if (n != E) begin errors++; $display("FAIL flush_busy_len: got %0d cycles want %0d", n, E); end
    drive(1, 32'h100, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++; $display("FAIL flush_pred: got %b want 0", bp.pred_taken); end
    checks++; if (bp.stat_branches !== 32'd10 || bp.stat_mispredicts !== 32'd3) begin
      errors++; $display("FAIL flush_stats: got %0d/%0d want 10/3", bp.stat_branches, bp.stat_mispredicts); end
  endtask
`else
  task automatic test_gshare();
    do_reset();
    repeat (E) cyc();
    drive(0, 0, 1, 32'h100, 1, 0, 0); cyc();
    drive(0, 0, 1, 32'h100, 1, 0, 0); cyc();
    drive(0, 0, 1, 32'h100, 0, 0, 0); cyc();
    checks++; if (ghr != 6) begin errors++; $display("FAIL gshare_model_ghr: got %0d want 6", ghr); end
    drive(1, 32'h100, 0, 0, 0, 0, 0); cyc();
    checks++; if (bp.pred_taken !== 1'b0) begin errors++; $display("FAIL gshare_pred: got %b want 0", bp.pred_taken); end
  endtask
`endif
  task automatic test_random();
    logic [31:0] lpc, upc;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      lpc = 32'h1000 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
      upc = ($urandom_range(0, 3) == 0) ? lpc : 32'h1000 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
      drive($urandom_range(0, 1), lpc, $urandom_range(0, 2) != 0, upc, $urandom_range(0, 1),
            $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      cyc();
      checks++; if (bp.pred_valid !== exp_pv || bp.pred_taken !== exp_pt) begin
        errors++; $display("FAIL rnd_pred c=%0d: got v=%b t=%b want v=%b t=%b", c, bp.pred_valid, bp.pred_taken, exp_pv, exp_pt); end
      checks++; if (bp.busy !== (busy_left > 0)) begin
        errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, bp.busy, busy_left > 0); end
      checks++; if (bp.stat_branches !== 32'(m_br) || bp.stat_mispredicts !== 32'(m_mp)) begin
        errors++; $display("FAIL rnd_stats c=%0d: got %0d/%0d want %0d/%0d", c, bp.stat_branches, bp.stat_mispredicts, m_br, m_mp); end
    end
  endtask
  initial begin
    test_reset();
`ifndef BP_GSHARE_EN
    test_training();
    test_saturation();
    test_conflict();
    test_flush();
`else
    test_gshare();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
